// File: rtl/instr_fetch_queue.sv
// Fetch stage with a prefetch queue between instruction memory and decode.
// Owns the fetch PC, buffers {instr, PC+4} pairs, and flushes on redirect.
module instr_fetch_queue #(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic [XLEN-1:0]  startPC,
  input  logic             fetch_en,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [XLEN-1:0]  imem_data,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             deq_ready,
  output logic             deq_valid,
  output logic [XLEN-1:0]  deq_instr,
  output logic [XLEN-1:0]  deq_pcplus4,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_plus4;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [XLEN-1:0]  instr_mem [DEPTH];
  logic [XLEN-1:0]  pcp4_mem  [DEPTH];
  logic             enq;
  logic             deq;

  assign pc_plus4  = pc + XLEN'(4);
  assign imem_addr = pc;
  assign full      = (count == CNT_W'(DEPTH));
  assign deq_valid = (count != '0);

  // A redirect overrides both handshakes, so neither side moves that cycle.
  assign deq = deq_ready & deq_valid & ~redirect;
  assign enq = fetch_en & (~full | deq) & ~redirect;

  assign deq_instr   = deq_valid ? instr_mem[rd_ptr] : '0;
  assign deq_pcplus4 = deq_valid ? pcp4_mem[rd_ptr]  : '0;

  always_ff @(negedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      pc     <= startPC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      pc     <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        pc     <= pc_plus4;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (enq && !deq) begin
        count <= count + CNT_W'(1);
      end else if (!enq && deq) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Storage needs no reset: the head outputs are gated by the count.
  always_ff @(negedge CLK) begin
    if (enq) begin
      instr_mem[wr_ptr] <= imem_data;
      pcp4_mem[wr_ptr]  <= pc_plus4;
    end
  end

endmodule
